nano_lockstep_checker: RTL and testbench

// - Parametrised lockstep comparator between the NanoController RTL (TB side) and the reference model (REF side).
// - Compares NUM_CH packed channels per sample with a per-channel mask.
// - A skew FIFO tolerates REF lagging TB by up to SKEW_D samples.
// - Counts mismatches and captures the first failing channel and cycle.
// - Sits in the sim/sv bench next to the DUT and the model, gated by boot-done.

---
 rtl/nano_lockstep_checker.sv | 194 +++++++++++++++++++
 tb/tb_nano_lockstep_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nano_lockstep_checker.sv
// Lockstep comparator: TB samples are queued in a skew FIFO and checked against lagging REF samples.
// Optional build macro NANO_CHK_FATAL_EN adds simulation-only $fatal reporting and a [FUNC] change trace.
module nano_lockstep_checker #(
   parameter int NUM_CH    = 8,
   parameter int CH_W      = 16,
   parameter int SKEW_D    = 4,
   parameter int ERR_LIMIT = 1
) (
   input  logic                      i_nano_clk,
   input  logic                      i_nano_rst,
   input  logic                      i_enable,
   input  logic [NUM_CH-1:0]         i_ch_mask,
   input  logic                      i_tb_valid,
   input  logic [NUM_CH*CH_W-1:0]    i_tb_vec,
   input  logic                      i_ref_valid,
   input  logic [NUM_CH*CH_W-1:0]    i_ref_vec,
   output logic [1:0]                o_state,
   output logic                      o_mismatch,
   output logic [15:0]               o_err_cnt,
   output logic [$clog2(NUM_CH)-1:0] o_first_ch,
   output logic [31:0]               o_first_cyc,
   output logic                      o_ovf,
   output logic                      o_change
);
   localparam int VEC_W = NUM_CH*CH_W;
   localparam int AW    = $clog2(SKEW_D);
   localparam int IW    = $clog2(NUM_CH);
   localparam logic [AW:0] DEPTH = (AW+1)'(SKEW_D);
   localparam logic [15:0] LIMIT = 16'(ERR_LIMIT);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_t;

   function automatic logic [NUM_CH-1:0] ch_fail(input logic [VEC_W-1:0] a,
                                                 input logic [VEC_W-1:0] b,
                                                 input logic [NUM_CH-1:0] m);
      logic [NUM_CH-1:0] f;
      f = '0;
      for (int k = 0; k < NUM_CH; k++)
         f[k] = m[k] && (a[k*CH_W +: CH_W] !== b[k*CH_W +: CH_W]);
      return f;
   endfunction

   function automatic logic [IW-1:0] lowest_idx(input logic [NUM_CH-1:0] f);
      logic [IW-1:0] idx;
      idx = '0;
      for (int k = NUM_CH-1; k >= 0; k--)
         if (f[k]) idx = IW'(k);
      return idx;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t            r_state;
   logic [VEC_W-1:0]  r_mem [SKEW_D];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_cnt;
   logic [31:0]       r_cyc;
   logic [VEC_W-1:0]  r_prev;
   logic              r_mismatch_p1;
   logic              r_change_p1;
   logic [15:0]       r_err_cnt;
   logic [IW-1:0]     r_first_ch;
   logic [31:0]       r_first_cyc;
   logic              r_ovf;

   logic              w_run, w_push, w_pop, w_empty, w_full;
   logic              w_bypass, w_ovf_ev, w_cmp, w_wr, w_rd;
   logic [VEC_W-1:0]  w_head;
   logic [NUM_CH-1:0] w_fail;
   logic [15:0]       w_err_nxt;

   assign w_run     = (r_state == ST_RUN) && i_enable;
   assign w_push    = w_run && i_tb_valid;
   assign w_pop     = w_run && i_ref_valid;
   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == DEPTH);
   assign w_bypass  = w_empty && w_push && w_pop;
   assign w_ovf_ev  = (w_full && w_push && !w_pop) || (w_empty && w_pop && !w_push);
   assign w_cmp     = w_pop && !(w_empty && !w_push);
   assign w_wr      = w_push && !w_bypass && !(w_full && !w_pop);
   assign w_rd      = w_pop && !w_empty;
   // A pop on an empty FIFO with a simultaneous push compares straight against the incoming TB sample.
   assign w_head    = w_bypass ? i_tb_vec : r_mem[r_rd_ptr];
   assign w_fail    = ch_fail(w_head, i_ref_vec, i_ch_mask);
   assign w_err_nxt = sat_inc(r_err_cnt);

   always_ff @(posedge i_nano_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_tb_vec;
   end

   // Stage p0 -> p1: compare result and FIFO/control state registered on the pop edge
   always_ff @(posedge i_nano_clk) begin
      if (i_nano_rst) begin
         r_state       <= ST_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_cnt         <= '0;
         r_cyc         <= '0;
         r_prev        <= '0;
         r_mismatch_p1 <= 1'b0;
         r_change_p1   <= 1'b0;
         r_err_cnt     <= '0;
         r_first_ch    <= '0;
         r_first_cyc   <= '0;
         r_ovf         <= 1'b0;
      end else begin
         r_mismatch_p1 <= 1'b0;
         r_change_p1   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_enable) r_state <= ST_RUN;
            end
            ST_RUN: begin
               r_cyc <= r_cyc + 32'd1;
               if (!i_enable) begin
                  r_state  <= ST_IDLE;
                  r_wr_ptr <= '0;
                  r_rd_ptr <= '0;
                  r_cnt    <= '0;
               end else begin
                  if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
                  if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
                  else if (!w_wr && w_rd) r_cnt <= r_cnt - 1'b1;
                  if (w_ovf_ev) begin
                     r_ovf   <= 1'b1;
                     r_state <= ST_HALT;
                  end
                  if (w_cmp) begin
                     r_prev      <= w_head;
                     r_change_p1 <= (w_head !== r_prev);
                     if (|w_fail) begin
                        r_mismatch_p1 <= 1'b1;
                        r_err_cnt     <= w_err_nxt;
                        if (r_err_cnt == 16'd0) begin
                           r_first_ch  <= lowest_idx(w_fail);
                           r_first_cyc <= r_cyc;
                        end
                        if (w_err_nxt >= LIMIT) r_state <= ST_HALT;
                     end
                  end
               end
            end
            default: r_state <= ST_HALT;
         endcase
      end
   end

   assign o_state     = r_state;
   assign o_mismatch  = r_mismatch_p1;
   assign o_change    = r_change_p1;
   assign o_err_cnt   = r_err_cnt;
   assign o_first_ch  = r_first_ch;
   assign o_first_cyc = r_first_cyc;
   assign o_ovf       = r_ovf;

`ifdef NANO_CHK_FATAL_EN
   logic [VEC_W-1:0]  r_tb_p1;
   logic [VEC_W-1:0]  r_ref_p1;
   logic [NUM_CH-1:0] r_fail_p1;
   logic              r_ovf_ev_p1;

   always_ff @(posedge i_nano_clk) begin
      r_ovf_ev_p1 <= !i_nano_rst && w_ovf_ev;
      if (w_cmp) begin
         r_tb_p1   <= w_head;
         r_ref_p1  <= i_ref_vec;
         r_fail_p1 <= w_fail;
      end
   end

   always @(posedge i_nano_clk) begin
      string  s;
      int     ch;
      if (r_change_p1) begin
         s = "[FUNC]";
         for (int k = NUM_CH-1; k >= 0; k--)
            s = $sformatf("%s %03d", s, r_tb_p1[k*CH_W +: CH_W]);
         $display("%s", s);
      end
      if (r_mismatch_p1) begin
         ch = int'(lowest_idx(r_fail_p1));
         $fatal(1, "nano_lockstep_checker: ch %0d tb=%h ref=%h at %0t", ch,
                r_tb_p1[ch*CH_W +: CH_W], r_ref_p1[ch*CH_W +: CH_W], $realtime);
      end
      if (r_ovf_ev_p1)
         $fatal(1, "nano_lockstep_checker: skew FIFO overflow/underflow at %0t", $realtime);
   end
`endif

endmodule

// File: tb/tb_nano_lockstep_checker.sv
// Scoreboard bench for nano_lockstep_checker: per-cycle expected state/pulses queued by the driver,
// popped and compared by an independent monitor; end-of-test counters checked directly.
module tb_nano_lockstep_checker;
   localparam int NUM_CH = 8;
   localparam int CH_W   = 16;
   localparam int W      = NUM_CH*CH_W;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [7:0]    mask = 8'hFF;
   logic          tb_valid = 1'b0;
   logic [W-1:0]  tb_vec = '0;
   logic          ref_valid = 1'b0;
   logic [W-1:0]  ref_vec = '0;
   logic [1:0]    o_state;
   logic          o_mismatch;
   logic [15:0]   o_err_cnt;
   logic [2:0]    o_first_ch;
   logic [31:0]   o_first_cyc;
   logic          o_ovf;
   logic          o_change;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0] st;
      logic       mis;
      logic       chg;
      string      nm;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   nano_lockstep_checker #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SKEW_D(4), .ERR_LIMIT(1)) dut (
      .i_nano_clk (clk),
      .i_nano_rst (rst),
      .i_enable   (en),
      .i_ch_mask  (mask),
      .i_tb_valid (tb_valid),
      .i_tb_vec   (tb_vec),
      .i_ref_valid(ref_valid),
      .i_ref_vec  (ref_vec),
      .o_state    (o_state),
      .o_mismatch (o_mismatch),
      .o_err_cnt  (o_err_cnt),
      .o_first_ch (o_first_ch),
      .o_first_cyc(o_first_cyc),
      .o_ovf      (o_ovf),
      .o_change   (o_change)
   );

   // Monitor: one expected entry per driven cycle, observed just after the edge that consumed it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if ({o_state, o_mismatch, o_change} !== {e.st, e.mis, e.chg}) begin
               n_err++;
               $display("FAIL %s: state/mis/chg got %0d/%b/%b expected %0d/%b/%b",
                        e.nm, o_state, o_mismatch, o_change, e.st, e.mis, e.chg);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [W-1:0] vec(input int i);
      logic [W-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_CH; k++) v[k*CH_W +: CH_W] = 16'(i*16 + k + 1);
      return v;
   endfunction

   task automatic step(input logic r, input logic e, input logic tv, input logic [W-1:0] tvv,
                       input logic rv, input logic [W-1:0] rvv,
                       input logic [1:0] est, input logic emis, input logic echg, input string nm);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; tb_valid = tv; tb_vec = tvv; ref_valid = rv; ref_vec = rvv;
      x.st = est; x.mis = emis; x.chg = echg; x.nm = nm;
      q.push_back(x);
   endtask

   task automatic drain();
      @(negedge clk);
      tb_valid = 1'b0; ref_valid = 1'b0;
      for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic start();
      step(1, 0, 0, '0, 0, '0, S_IDLE, 0, 0, "reset");
      step(0, 1, 0, '0, 0, '0, S_RUN,  0, 0, "enable");
   endtask

   task automatic run_skew(input int s, input int n, input string nm);
      for (int i = 0; i < n + s; i++)
         step(0, 1, i < n, (i < n) ? vec(i) : '0, i >= s, (i >= s) ? vec(i - s) : '0,
              S_RUN, 0, i >= s, nm);
   endtask

   initial begin
      logic [W-1:0] bad;
      logic [W-1:0] alt;

      // reset state
      step(1, 0, 0, '0, 0, '0, S_IDLE, 0, 0, "reset_hold");
      drain();
      chk("reset_err_cnt", 32'(o_err_cnt), 0);
      chk("reset_ovf", 32'(o_ovf), 0);

      // zero skew, 100 identical samples
      start();
      run_skew(0, 100, "skew0");
      drain();
      chk("skew0_err_cnt", 32'(o_err_cnt), 0);
      chk("skew0_ovf", 32'(o_ovf), 0);
      chk("skew0_state", 32'(o_state), 32'(S_RUN));

      // skew 3 and skew 4 (full FIFO with push+pop) are tolerated
      start();
      run_skew(3, 20, "skew3");
      drain();
      chk("skew3_err_cnt", 32'(o_err_cnt), 0);
      chk("skew3_ovf", 32'(o_ovf), 0);
      start();
      run_skew(4, 12, "skew4");
      drain();
      chk("skew4_ovf", 32'(o_ovf), 0);
      chk("skew4_state", 32'(o_state), 32'(S_RUN));

      // skew 5 overflows a 4-deep FIFO
      start();
      for (int i = 0; i < 4; i++) step(0, 1, 1, vec(i), 0, '0, S_RUN, 0, 0, "skew5_fill");
      step(0, 1, 1, vec(4), 0, '0, S_HALT, 0, 0, "skew5_ovf");
      step(0, 1, 1, vec(5), 1, vec(0), S_HALT, 0, 0, "skew5_halted");
      drain();
      chk("skew5_ovf", 32'(o_ovf), 1);
      chk("skew5_err_cnt", 32'(o_err_cnt), 0);

      // mismatch on channels 2 and 5 at RUN cycle 17
      start();
      for (int j = 0; j < 17; j++) step(0, 1, 1, vec(j), 1, vec(j), S_RUN, 0, 1, "mis_pre");
      bad = vec(17);
      bad[2*CH_W +: CH_W] = bad[2*CH_W +: CH_W] ^ 16'h0001;
      bad[5*CH_W +: CH_W] = bad[5*CH_W +: CH_W] ^ 16'h0100;
      step(0, 1, 1, vec(17), 1, bad, S_HALT, 1, 1, "mis_hit");
      step(0, 1, 1, vec(18), 1, vec(18), S_HALT, 0, 0, "mis_halted");
      drain();
      chk("mis_first_ch", 32'(o_first_ch), 2);
      chk("mis_first_cyc", o_first_cyc, 17);
      chk("mis_err_cnt", 32'(o_err_cnt), 1);
      chk("mis_ovf", 32'(o_ovf), 0);

      // reset mid-operation clears everything
      step(1, 0, 0, '0, 0, '0, S_IDLE, 0, 0, "mid_reset");
      drain();
      chk("rst_err_cnt", 32'(o_err_cnt), 0);
      chk("rst_first_ch", 32'(o_first_ch), 0);
      chk("rst_first_cyc", o_first_cyc, 0);

      // masked channel 2: no mismatch, but TB change still reported
      mask = 8'hFB;
      start();
      alt = vec(0);
      alt[2*CH_W +: CH_W] = 16'h0ABC;
      step(0, 1, 1, vec(0), 1, vec(0), S_RUN, 0, 1, "mask_first");
      step(0, 1, 1, alt, 1, vec(0), S_RUN, 0, 1, "mask_ch2_changed");
      step(0, 1, 1, alt, 1, vec(0), S_RUN, 0, 0, "mask_repeat");
      drain();
      chk("mask_err_cnt", 32'(o_err_cnt), 0);
      mask = 8'hFF;

      // underflow, then a one-cycle reset
      start();
      step(0, 1, 0, '0, 1, vec(0), S_HALT, 0, 0, "underflow");
      drain();
      chk("udf_ovf", 32'(o_ovf), 1);
      step(1, 0, 0, '0, 0, '0, S_IDLE, 0, 0, "udf_reset");
      step(0, 0, 0, '0, 0, '0, S_IDLE, 0, 0, "udf_idle");
      drain();
      chk("udf_rst_ovf", 32'(o_ovf), 0);
      chk("udf_rst_err_cnt", 32'(o_err_cnt), 0);

      // dropping enable flushes queued samples, so a later lone pop underflows
      start();
      step(0, 1, 1, vec(0), 0, '0, S_RUN, 0, 0, "flush_push0");
      step(0, 1, 1, vec(1), 0, '0, S_RUN, 0, 0, "flush_push1");
      step(0, 0, 0, '0, 0, '0, S_IDLE, 0, 0, "flush_disable");
      step(0, 1, 0, '0, 0, '0, S_RUN, 0, 0, "flush_reenable");
      step(0, 1, 0, '0, 1, vec(0), S_HALT, 0, 0, "flush_pop_empty");
      drain();
      chk("flush_ovf", 32'(o_ovf), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
